// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared widths and FSM state encoding for the symmetric FIR
//               multiply-accumulate stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // Tap sample, coefficient and result widths
    localparam int DATA_W = 4;
    localparam int COEF_W = 4;
    localparam int OUT_W  = 11;

    // Clamp width applied to the final sum when FIR_SAT_EN is defined
    localparam int SAT_W  = 8;

    // Pre-added pair width (one extra bit absorbs the pair sum)
    localparam int PRE_W  = DATA_W + 1;

    // Full-precision product width of one coefficient times one pre-add
    localparam int PROD_W = PRE_W + COEF_W;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_preadd.sv
`default_nettype none
// ============================================================================
// Module      : fir_preadd
// Description : Combinational symmetric pre-adder. Folds the five tap samples
//               into two pair sums and a sign-extended centre tap.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_preadd
    import fir_pkg::*;
(
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    input  logic signed [DATA_W-1:0] x4,
    output logic signed [PRE_W-1:0]  p0,
    output logic signed [PRE_W-1:0]  p1,
    output logic signed [PRE_W-1:0]  p2
);

    // Explicitly sign-extended copies so the pair sums cannot wrap
    logic signed [PRE_W-1:0] w_x0_ext;
    logic signed [PRE_W-1:0] w_x1_ext;
    logic signed [PRE_W-1:0] w_x2_ext;
    logic signed [PRE_W-1:0] w_x3_ext;
    logic signed [PRE_W-1:0] w_x4_ext;

    assign w_x0_ext = {x0[DATA_W-1], x0};
    assign w_x1_ext = {x1[DATA_W-1], x1};
    assign w_x2_ext = {x2[DATA_W-1], x2};
    assign w_x3_ext = {x3[DATA_W-1], x3};
    assign w_x4_ext = {x4[DATA_W-1], x4};

    // Outer pair, inner pair and centre tap
    assign p0 = w_x0_ext + w_x4_ext;
    assign p1 = w_x1_ext + w_x3_ext;
    assign p2 = w_x2_ext;

endmodule : fir_preadd
`default_nettype wire

// File: rtl/fir_sym_mac.sv
`default_nettype none
// ============================================================================
// Module      : fir_sym_mac
// Description : Symmetric 5-tap FIR arithmetic stage. Computes
//               y = c0*(x0+x4) + c1*(x1+x3) + c2*x2 with a single multiplier
//               time-shared over three cycles, valid/ready on both sides.
//               Optional macro FIR_SAT_EN clamps the result to SAT_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sym_mac
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    input  logic signed [DATA_W-1:0] x4,
    input  logic signed [COEF_W-1:0] c0,
    input  logic signed [COEF_W-1:0] c1,
    input  logic signed [COEF_W-1:0] c2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  y
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [1:0]              r_idx;
    logic signed [PRE_W-1:0] r_p0;
    logic signed [PRE_W-1:0] r_p1;
    logic signed [PRE_W-1:0] r_p2;
    logic signed [COEF_W-1:0] r_c0;
    logic signed [COEF_W-1:0] r_c1;
    logic signed [COEF_W-1:0] r_c2;
    logic signed [OUT_W-1:0] r_acc;
    logic signed [OUT_W-1:0] r_y;
    logic                    r_out_valid;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic signed [PRE_W-1:0]  w_p0;
    logic signed [PRE_W-1:0]  w_p1;
    logic signed [PRE_W-1:0]  w_p2;
    logic signed [PRE_W-1:0]  w_pre;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [OUT_W-1:0]  w_prod_ext;
    logic signed [OUT_W-1:0]  w_acc_base;
    logic signed [OUT_W-1:0]  w_sum;
    logic signed [OUT_W-1:0]  w_final;
    logic                     w_accept;

    fir_preadd u_preadd (
        .x0 (x0),
        .x1 (x1),
        .x2 (x2),
        .x3 (x3),
        .x4 (x4),
        .p0 (w_p0),
        .p1 (w_p1),
        .p2 (w_p2)
    );

    // A new vector may enter from IDLE, or from HOLD in the same cycle the
    // pending result is taken, which gives back-to-back operation.
    assign in_ready  = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;

    // Select the coefficient / pre-add pair for the current MAC step
    always_comb begin
        w_pre  = '0;
        w_coef = '0;
        case (r_idx)
            2'd0: begin
                w_pre  = r_p0;
                w_coef = r_c0;
            end
            2'd1: begin
                w_pre  = r_p1;
                w_coef = r_c1;
            end
            2'd2: begin
                w_pre  = r_p2;
                w_coef = r_c2;
            end
            default: begin
                w_pre  = '0;
                w_coef = '0;
            end
        endcase
    end

    // Single shared signed multiplier; the first step restarts the sum
    assign w_prod     = w_coef * w_pre;
    assign w_prod_ext = {{(OUT_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_acc_base = (r_idx == 2'd0) ? '0 : r_acc;
    assign w_sum      = w_acc_base + w_prod_ext;

`ifdef FIR_SAT_EN
    localparam logic signed [OUT_W-1:0] SAT_MAX = OUT_W'((1 <<< (SAT_W-1)) - 1);
    localparam logic signed [OUT_W-1:0] SAT_MIN = OUT_W'(-(1 <<< (SAT_W-1)));

    // Clamp the completed sum into the narrower signed range
    always_comb begin
        w_final = w_sum;
        if (w_sum > SAT_MAX) begin
            w_final = SAT_MAX;
        end else if (w_sum < SAT_MIN) begin
            w_final = SAT_MIN;
        end
    end
`else
    assign w_final = w_sum;
`endif

    // Controller, operand capture, accumulator and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_p0        <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_c0        <= '0;
            r_c1        <= '0;
            r_c2        <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_p0    <= w_p0;
                        r_p1    <= w_p1;
                        r_p2    <= w_p2;
                        r_c0    <= c0;
                        r_c1    <= c1;
                        r_c2    <= c2;
                        r_idx   <= 2'd0;
                        r_state <= MAC;
                    end
                end

                MAC: begin
                    r_acc <= w_sum;
                    if (r_idx == 2'd2) begin
                        r_y         <= w_final;
                        r_out_valid <= 1'b1;
                        r_idx       <= 2'd0;
                        r_state     <= HOLD;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_p0    <= w_p0;
                            r_p1    <= w_p1;
                            r_p2    <= w_p2;
                            r_c0    <= c0;
                            r_c1    <= c1;
                            r_c2    <= c2;
                            r_idx   <= 2'd0;
                            r_state <= MAC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_idx       <= 2'd0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : fir_sym_mac
`default_nettype wire

// File: tb/tb_fir_sym_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_sym_mac
// Description : Self-checking bench for fir_sym_mac with a behavioural model
//               of the symmetric FIR sum (honours FIR_SAT_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sym_mac;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [3:0] x0, x1, x2, x3, x4;
    logic signed [3:0] c0, c1, c2;
    logic              out_valid;
    logic              out_ready;
    logic signed [10:0] y;

    int vectors;
    int miscompares;

    fir_sym_mac dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the symmetric FIR equation
    function automatic int ref_y(input logic [19:0] xv, input logic [11:0] cv);
        int xs [5];
        int cs [3];
        int s;
        for (int i = 0; i < 5; i++) xs[i] = int'($signed(xv[4*i +: 4]));
        for (int i = 0; i < 3; i++) cs[i] = int'($signed(cv[4*i +: 4]));
        s = cs[0] * (xs[0] + xs[4]) + cs[1] * (xs[1] + xs[3]) + cs[2] * xs[2];
`ifdef FIR_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [19:0] xv, input logic [11:0] cv);
        x0 = xv[3:0];   x1 = xv[7:4];   x2 = xv[11:8];
        x3 = xv[15:12]; x4 = xv[19:16];
        c0 = cv[3:0];   c1 = cv[7:4];   c2 = cv[11:8];
    endtask

    // x = [1,2,3,2,1] (x0 in low nibble), c = [1,2,3]
    localparam logic [19:0] X_BASIC = 20'h12321;
    localparam logic [11:0] C_BASIC = 12'h321;

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive('0, '0);
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || y !== 11'sd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: out_valid=%b y=%0d in_ready=%b, required 0/0/1", out_valid, y, in_ready);
        end
    endtask

    task automatic test_basic();
        int lat, low;
        int e;
        e = ref_y(X_BASIC, C_BASIC);
        drive(X_BASIC, C_BASIC);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1; low = 0;
        while (!out_valid && lat < 12) begin
            if (!in_ready) low++;
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL basic_latency: edges to out_valid=%0d, required 3", lat - 1);
        end
        vectors++;
        if (low !== 3) begin
            miscompares++;
            $display("FAIL basic_in_ready_low: cycles=%0d, required 3", low);
        end
        vectors++;
        if (y !== 11'(e)) begin
            miscompares++;
            $display("FAIL basic_y: y=%0d, required %0d", y, e);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_drain: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    // Run one vector through an idle DUT and compare the result
    task automatic run_one(input logic [19:0] xv, input logic [11:0] cv,
                           input int stall, input string name);
        int e, n;
        e = ref_y(xv, cv);
        drive(xv, cv);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < stall; i++) tick();
        vectors++;
        if (out_valid !== 1'b1 || y !== 11'(e)) begin
            miscompares++;
            $display("FAIL %s: out_valid=%b y=%0d, required 1/%0d", name, out_valid, y, e);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_corner();
        run_one(20'h88888, 12'h888, 0, "corner_pos");
        run_one(20'h88888, 12'h777, 0, "corner_neg");
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            run_one(20'($urandom), 12'($urandom), int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_backpressure();
        int e, n;
        e = ref_y(X_BASIC, C_BASIC);
        drive(X_BASIC, C_BASIC);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(20'($urandom), 12'($urandom));
            vectors++;
            if (out_valid !== 1'b1 || y !== 11'(e) || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold: out_valid=%b y=%0d in_ready=%b, required 1/%0d/0",
                         out_valid, y, in_ready, e);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_once: out_valid=%b, required 0", out_valid);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] xq [$];
        logic [11:0] cq [$];
        int expq [$];
        int sent, ncons, last, cyc, nvec, e;
        logic acc_now, cons_now;
        logic signed [10:0] y_now;
        xq.push_back(X_BASIC);  cq.push_back(C_BASIC);
        xq.push_back(20'h88888); cq.push_back(12'h888);
        for (int k = 0; k < 3; k++) begin
            xq.push_back(20'($urandom)); cq.push_back(12'($urandom));
        end
        nvec = xq.size();
        for (int k = 0; k < nvec; k++) expq.push_back(ref_y(xq[k], cq[k]));
        sent = 0; ncons = 0; last = -1; cyc = 0;
        out_ready = 1'b1; in_valid = 1'b1;
        drive(xq[0], cq[0]);
        while (ncons < nvec && cyc < 80) begin
            acc_now  = in_valid && in_ready;
            cons_now = out_valid && out_ready;
            y_now    = y;
            tick();
            cyc++;
            if (cons_now) begin
                e = expq.pop_front();
                vectors++;
                if (y_now !== 11'(e)) begin
                    miscompares++;
                    $display("FAIL b2b_value[%0d]: y=%0d, required %0d", ncons, y_now, e);
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last !== 4) begin
                        miscompares++;
                        $display("FAIL b2b_spacing[%0d]: cycles=%0d, required 4", ncons, cyc - last);
                    end
                end
                last = cyc;
                ncons++;
            end
            if (acc_now) begin
                sent++;
                if (sent < nvec) drive(xq[sent], cq[sent]);
                else in_valid = 1'b0;
            end
        end
        vectors++;
        if (ncons !== nvec) begin
            miscompares++;
            $display("FAIL b2b_count: results=%0d, required %0d", ncons, nvec);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_duplicate: out_valid=%b, required 0", out_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_mac();
        drive(20'($urandom), 12'($urandom));
        in_valid = 1'b1; out_ready = 1'b1;
        tick();                 // accept
        in_valid = 1'b0;
        tick();                 // first MAC step done, idx now 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || y !== 11'sd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_mac: out_valid=%b y=%0d in_ready=%b, required 0/0/1",
                     out_valid, y, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_pulse: out_valid=%b, required 0", out_valid);
            end
            tick();
        end
        run_one(X_BASIC, C_BASIC, 0, "reset_recover");
    endtask

    task automatic test_holdoff();
        logic [19:0] xa;
        logic [11:0] ca;
        int e, n;
        for (int k = 0; k < 4; k++) begin
            xa = 20'($urandom); ca = 12'($urandom);
            e = ref_y(xa, ca);
            drive(xa, ca);
            in_valid = 1'b1; out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 10) begin
                drive(20'($urandom), 12'($urandom));
                tick();
                n++;
            end
            drive(20'($urandom), 12'($urandom));
            vectors++;
            if (out_valid !== 1'b1 || y !== 11'(e)) begin
                miscompares++;
                $display("FAIL holdoff: out_valid=%b y=%0d, required 1/%0d", out_valid, y, e);
            end
            out_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_corner();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mac();
        test_holdoff();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fir_sym_mac
`default_nettype wire
